encoder_round_sequencer: RTL and testbench
==========================================

Name: encoder_round_sequencer

Overview:
- Top-level scheduler for the matrix encoder. Runs the function blocks (colParity, rotate, permute, revaluate, addRC) in fixed order for NUM_ROUNDS rounds over the shared 64-line, 25-bit state memory.
- Launches one stage at a time with a start/done handshake.
- Acts as arbiter for the single memory write port: only the active stage's write request is forwarded.
- Flags protocol violations and hung stages.

Parameters:
NUM_STAGES, 5, number of function blocks sequenced per round (stage 0 first)
NUM_ROUNDS, 24, rounds per encode operation
LINE_W, 25, memory line width
ADDR_W, 7, line address / cnt_value width
TIMEOUT, 1023, max cycles a stage may spend in WAIT before error

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
start  input  1  request a full encode; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last stage of the last round completes
err  output  1  sticky error flag
round  output  5  current round index
stage  output  3  current stage index
stage_start  output  NUM_STAGES  one-hot, one-cycle launch pulse to the selected stage
stage_done  input  NUM_STAGES  per-stage completion (level or pulse)
stage_we  input  NUM_STAGES  per-stage write request
stage_addr  input  NUM_STAGES*ADDR_W  flattened per-stage write address; stage i occupies bits [i*ADDR_W +: ADDR_W]
stage_wdata  input  NUM_STAGES*LINE_W  flattened per-stage write data, same packing
mem_we  output  1  arbitrated write enable to state memory
mem_addr  output  ADDR_W  arbitrated address
mem_wdata  output  LINE_W  arbitrated data

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; round=0; stage=0.
  - busy, done, err, stage_start, mem_we = 0; mem_addr=0; mem_wdata=0.
  - Reset mid-operation aborts immediately; no further stage_start is issued.
- FSM states: IDLE, LAUNCH, WAIT, ADVANCE, FINISH. All outputs are Moore/registered decodes of state, round and stage.
- IDLE:
  - start=1 -> LAUNCH with round=0, stage=0, err cleared, timeout counter cleared.
  - start=0 -> stay in IDLE.
- LAUNCH:
  - stage_start[stage]=1 for exactly this cycle, all other bits 0.
  - stage_done is ignored in this cycle, so a stale level from a prior stage is not counted.
  - Unconditionally -> WAIT; timeout counter reset to 0.
- WAIT:
  - Arbiter is transparent for the active stage only: mem_we=stage_we[stage], mem_addr=stage_addr[stage], mem_wdata=stage_wdata[stage].
  - Requests from inactive stages are dropped, never queued.
  - stage_done[stage]=1 -> ADVANCE. A write requested in that same cycle is still forwarded.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT, set err=1 and go -> IDLE with no done pulse.
- ADVANCE (mem_we=0):
  - stage<NUM_STAGES-1 -> stage+1, then LAUNCH.
  - stage==NUM_STAGES-1 and round<NUM_ROUNDS-1 -> stage=0, round+1, then LAUNCH.
  - stage==NUM_STAGES-1 and round==NUM_ROUNDS-1 -> FINISH.
- FINISH:
  - done=1 for one cycle; round and stage hold their final values.
  - Next cycle -> IDLE, where round and stage reset to 0.
- Outside WAIT: mem_we=0, mem_addr=0, mem_wdata=0.
- start while busy: ignored; it does not restart the sequence and does not set err.
- Any stage_done bit for a non-active stage in LAUNCH, WAIT or ADVANCE sets err=1 (sticky) but does not alter sequencing.
- err clears only on reset or when a new start is accepted in IDLE.
- Timing cost per stage: 1 cycle LAUNCH + N cycles WAIT (including the cycle done is seen) + 1 cycle ADVANCE.
- Total latency from start accepted to done pulse: NUM_ROUNDS*NUM_STAGES*(N+2) + 1 cycles, with N uniform across stages.
- round and stage never exceed NUM_ROUNDS-1 and NUM_STAGES-1; no wrap-around beyond FINISH.

Test Plan:
1. Reset with rst=0 for 2 cycles while start=1 -> all outputs 0, state IDLE, no stage_start.
2. NUM_ROUNDS=2, NUM_STAGES=5; each stage model asserts done 3 cycles after its start pulse -> stage_start pulses in order 1,2,4,8,16 twice; done pulse exactly 2*5*5+1=51 cycles after start accepted; busy falls the cycle after done.
3. During WAIT of stage 2: stage 2 writes addr 5, data 0x1ABCDEF while stage 0 writes addr 9 -> mem_we=1, mem_addr=5, mem_wdata=0x1ABCDEF; stage 0's write is never seen.
4. TIMEOUT=8, stage 1 never asserts done -> err=1 after 8 WAIT cycles, return to IDLE, no done pulse; next start clears err and the sequence restarts at round 0, stage 0.
5. Stage 3 asserts done while stage 1 is active -> err=1, sequence continues normally and done still pulses at the expected cycle.
6. Assert rst=0 in round 1, stage 2 WAIT -> next cycle IDLE, round=0, mem_we=0; start pulse during busy in another run is ignored, shown by an unchanged done timing.

Source files
------------

// File: rtl/encoder_round_sequencer.sv
// encoder_round_sequencer
// Top-level scheduler for the matrix encoder. It walks the function blocks in
// fixed order (stage 0 first) for NUM_ROUNDS rounds. It launches one stage at a
// time with a start/done handshake and owns the single state-memory write port.
// It also raises a sticky error on stray completions and on hung stages.
module encoder_round_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int NUM_ROUNDS = 24,
  parameter int LINE_W     = 25,
  parameter int ADDR_W     = 7,
  parameter int TIMEOUT    = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [4:0]                   round,
  output logic [2:0]                   stage,
  output logic [NUM_STAGES-1:0]        stage_start,
  input  logic [NUM_STAGES-1:0]        stage_done,
  input  logic [NUM_STAGES-1:0]        stage_we,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr,
  input  logic [NUM_STAGES*LINE_W-1:0] stage_wdata,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_W-1:0]            mem_wdata
);

  // The WAIT counter only needs to reach TIMEOUT-1; the timeout fires on that cycle.
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]      LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam logic [4:0]      LAST_ROUND = 5'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ADVANCE,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [4:0]        r_round;
  logic [2:0]        r_stage;
  logic              r_err;
  logic [TO_W-1:0]   r_to_cnt;

  state_t            w_state_nxt;
  logic [4:0]        w_round_nxt;
  logic [2:0]        w_stage_nxt;
  logic              w_err_nxt;
  logic [TO_W-1:0]   w_to_nxt;

  logic [NUM_STAGES-1:0] w_sel;
  logic                  w_sel_done;
  logic                  w_sel_we;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [LINE_W-1:0]     w_sel_wdata;
  logic                  w_foreign_done;
  logic                  w_in_wait;

  // Decode the active stage: one-hot select plus its done/write request lanes.
  always_comb begin
    w_sel       = '0;
    w_sel_done  = 1'b0;
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_stage == 3'(i)) begin
        w_sel[i]    = 1'b1;
        w_sel_done  = stage_done[i];
        w_sel_we    = stage_we[i];
        w_sel_addr  = stage_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = stage_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  assign w_foreign_done = |(stage_done & ~w_sel);
  assign w_in_wait      = (r_state == S_WAIT);

  // Next-state logic for the sequencing FSM, round/stage indices, error flag and hang counter.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_stage_nxt = r_stage;
    w_err_nxt   = r_err;
    w_to_nxt    = r_to_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LAUNCH;
          w_round_nxt = '0;
          w_stage_nxt = '0;
          w_err_nxt   = 1'b0;
          w_to_nxt    = '0;
        end
      end

      // stage_done is not looked at here, so a level still held by the previous
      // stage can neither complete the new stage nor count as a stray completion.
      S_LAUNCH: begin
        w_state_nxt = S_WAIT;
        w_to_nxt    = '0;
      end

      S_WAIT: begin
        if (w_sel_done) begin
          w_state_nxt = S_ADVANCE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
        if (w_foreign_done) begin
          w_err_nxt = 1'b1;
        end
      end

      S_ADVANCE: begin
        if (r_stage != LAST_STAGE) begin
          w_stage_nxt = r_stage + 3'd1;
          w_state_nxt = S_LAUNCH;
        end else if (r_round != LAST_ROUND) begin
          w_stage_nxt = '0;
          w_round_nxt = r_round + 5'd1;
          w_state_nxt = S_LAUNCH;
        end else begin
          w_state_nxt = S_FINISH;
        end
        if (w_foreign_done) begin
          w_err_nxt = 1'b1;
        end
      end

      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Round and stage always read zero while idle.
    if (w_state_nxt == S_IDLE) begin
      w_round_nxt = '0;
      w_stage_nxt = '0;
    end
  end

  // State register with synchronous active-low reset that aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_round  <= '0;
      r_stage  <= '0;
      r_err    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_round  <= w_round_nxt;
      r_stage  <= w_stage_nxt;
      r_err    <= w_err_nxt;
      r_to_cnt <= w_to_nxt;
    end
  end

  // Status and launch outputs are pure decodes of the registered state.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FINISH);
  assign err         = r_err;
  assign round       = r_round;
  assign stage       = r_stage;
  assign stage_start = (r_state == S_LAUNCH) ? w_sel : '0;

  // Write-port arbiter: only the active stage passes, and only while waiting on it.
  assign mem_we    = w_in_wait & w_sel_we;
  assign mem_addr  = w_in_wait ? w_sel_addr  : '0;
  assign mem_wdata = w_in_wait ? w_sel_wdata : '0;

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// Scoreboard bench for encoder_round_sequencer: a behavioural stage model drives
// the handshakes, expected launches/writes/done times are queued and checked
// by an independent monitor.
module tb_encoder_round_sequencer;
  localparam int NS = 5;
  localparam int NR = 2;
  localparam int LW = 25;
  localparam int AW = 7;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;
  logic [4:0] round;
  logic [2:0] stage;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done = '0;
  logic [NS-1:0] stage_we = '0;
  logic [NS*AW-1:0] stage_addr = '0;
  logic [NS*LW-1:0] stage_wdata = '0;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;

  encoder_round_sequencer #(
    .NUM_STAGES(NS), .NUM_ROUNDS(NR), .LINE_W(LW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .round(round), .stage(stage), .stage_start(stage_start), .stage_done(stage_done),
    .stage_we(stage_we), .stage_addr(stage_addr), .stage_wdata(stage_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NS-1:0] oh;
    logic [4:0]    rnd;
    logic [2:0]    stg;
  } launch_t;

  launch_t            q_launch[$];
  logic [AW+LW-1:0]   q_wr[$];
  int                 q_done[$];

  // Stage behaviour table for the current run.
  int dly[0:NS*NR-1];
  int hang_launch = -1;
  int bad_launch = -1;
  bit noise_en = 1'b0;

  int cur = -1;
  int rem = 0;
  int lidx = 0;
  int wcnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural function blocks: respond to their launch pulse after dly cycles,
  // write randomly while running, and optionally misbehave.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [LW-1:0] w;
    int o;
    stage_done = '0;
    stage_we   = '0;
    for (int i = 0; i < NS; i++) begin
      stage_addr[i*AW +: AW]  = AW'($urandom());
      stage_wdata[i*LW +: LW] = LW'($urandom());
    end
    if (!busy) begin
      cur  = -1;
      lidx = 0;
    end else if (stage_start != '0) begin
      for (int i = 0; i < NS; i++) if (stage_start[i]) cur = i;
      rem  = (lidx == hang_launch) ? 100000 : dly[lidx];
      wcnt = 0;
      lidx++;
    end else if (cur >= 0) begin
      rem--;
      wcnt++;
      a = AW'($urandom());
      w = LW'($urandom());
      if (cur == 2 && wcnt == 1) begin
        a = 7'd5;
        w = 25'h1ABCDEF;
      end
      if ($urandom_range(0, 1) == 1 || (cur == 2 && wcnt == 1)) begin
        stage_we[cur] = 1'b1;
        stage_addr[cur*AW +: AW]  = a;
        stage_wdata[cur*LW +: LW] = w;
        q_wr.push_back({a, w});
      end
      if (noise_en) begin
        o = (cur == 0) ? 1 : 0;
        stage_we[o] = 1'b1;
        stage_addr[o*AW +: AW]  = 7'd9;
        stage_wdata[o*LW +: LW] = 25'h0155555;
      end
      if (lidx - 1 == bad_launch && wcnt == 1) begin
        o = (cur == 3) ? 4 : 3;
        stage_done[o] = 1'b1;
      end
      if (rem == 0) begin
        stage_done[cur] = 1'b1;
        cur = -1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a launch, write or done.
  bit prev_done = 1'b0;
  always begin
    launch_t          el;
    logic [AW+LW-1:0] ew;
    int               ed;
    @(negedge clk);
    #2;
    if (stage_start != '0) begin
      if (q_launch.size() == 0) begin
        checks++; errors++;
        $display("FAIL launch_unexpected: got %0h expected none", stage_start);
      end else begin
        el = q_launch.pop_front();
        check("launch_onehot", 64'(stage_start), 64'(el.oh));
        check("launch_round", 64'(round), 64'(el.rnd));
        check("launch_stage", 64'(stage), 64'(el.stg));
      end
    end
    if (mem_we === 1'b1) begin
      if (q_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL write_unexpected: got addr %0h data %0h expected none", mem_addr, mem_wdata);
      end else begin
        ew = q_wr.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(ew[AW+LW-1:LW]));
        check("wr_data", 64'(mem_wdata), 64'(ew[LW-1:0]));
      end
    end
    if (done === 1'b1) begin
      if (q_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        ed = q_done.pop_front();
        check("done_cycle", 64'(cyc), 64'(ed));
      end
    end
    if (prev_done) begin
      check("busy_after_done", 64'(busy), 64'd0);
      check("round_after_done", 64'(round), 64'd0);
    end
    prev_done = (done === 1'b1);
  end

  function automatic int lat();
    int s = 1;
    for (int k = 0; k < NS*NR; k++) s += dly[k] + 2;
    return s;
  endfunction

  task automatic set_dly(input bit rnd);
    for (int k = 0; k < NS*NR; k++) dly[k] = rnd ? int'($urandom_range(1, 6)) : 3;
  endtask

  // Drive a one-cycle start from idle and queue the expected launches and done time.
  task automatic issue_start(input int nlaunch, input bit expect_done, output int k0);
    launch_t e;
    @(negedge clk);
    start = 1'b1;
    k0 = cyc;
    for (int k = 0; k < nlaunch; k++) begin
      e.oh  = NS'(1) << (k % NS);
      e.rnd = 5'(k / NS);
      e.stg = 3'(k % NS);
      q_launch.push_back(e);
    end
    if (expect_done) q_done.push_back(k0 + lat());
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (busy && n < budget);
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #2;
    check({name, "_launch_q"}, 64'(q_launch.size()), 64'd0);
    check({name, "_write_q"}, 64'(q_wr.size()), 64'd0);
    check({name, "_done_q"}, 64'(q_done.size()), 64'd0);
  endtask

  task automatic goto(input int target);
    while (cyc < target) @(negedge clk);
    #2;
  endtask

  initial begin
    int k0;
    // Reset held with start asserted.
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_stage_start", 64'(stage_start), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    check("rst_stage", 64'(stage), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;

    // Uniform 3-cycle stages with an inactive stage writing addr 9 throughout.
    noise_en = 1'b1;
    set_dly(1'b0);
    issue_start(NS*NR, 1'b1, k0);
    wait_idle(500, "uniform");
    drain("uniform");
    check("uniform_err", 64'(err), 64'd0);

    // Randomised stage latencies, with a start pulse while busy that must be ignored.
    for (int r = 0; r < 4; r++) begin
      noise_en = ($urandom_range(0, 1) == 1);
      set_dly(1'b1);
      issue_start(NS*NR, 1'b1, k0);
      repeat ($urandom_range(3, 25)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(500, "random");
      drain("random");
      check("random_err", 64'(err), 64'd0);
    end

    // Stage 1 of round 0 hangs: error after TO wait cycles, no done pulse.
    noise_en = 1'b0;
    set_dly(1'b1);
    hang_launch = 1;
    issue_start(2, 1'b0, k0);
    goto(k0 + dly[0] + 11);
    check("hang_busy_last_wait", 64'(busy), 64'd1);
    check("hang_err_last_wait", 64'(err), 64'd0);
    @(negedge clk);
    #2;
    check("hang_busy_idle", 64'(busy), 64'd0);
    check("hang_err_set", 64'(err), 64'd1);
    hang_launch = -1;
    drain("hang");

    // Restart after the hang clears err and begins again at round 0, stage 0.
    set_dly(1'b1);
    issue_start(NS*NR, 1'b1, k0);
    #2;
    check("restart_err_cleared", 64'(err), 64'd0);
    wait_idle(500, "restart");
    drain("restart");

    // Stage 3 completes while stage 1 is active: sticky err, timing unchanged.
    set_dly(1'b1);
    bad_launch = 1;
    issue_start(NS*NR, 1'b1, k0);
    wait_idle(500, "stray");
    bad_launch = -1;
    drain("stray");
    check("stray_err", 64'(err), 64'd1);

    // Reset during the wait of round 1, stage 2 aborts the sequence.
    noise_en = 1'b1;
    set_dly(1'b0);
    issue_start(NS*NR, 1'b1, k0);
    goto(k0 + 37);
    check("abort_pre_round", 64'(round), 64'd1);
    check("abort_pre_stage", 64'(stage), 64'd2);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_round", 64'(round), 64'd0);
    check("abort_stage", 64'(stage), 64'd0);
    check("abort_mem_we", 64'(mem_we), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    q_launch.delete();
    q_done.delete();
    rst = 1'b1;
    repeat (10) @(negedge clk);
    drain("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion by %0t expected finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
